// File: rtl/cpu_req_queue.sv
// cpu_req_queue: single-clock request queue between the CPU model and the
// cache controller.
//
// The CPU side issues one-cycle sys_rd / sys_wr pulses. Each accepted request
// is buffered (up to DEPTH entries). The head entry is presented to the
// cache as a level request (c_rd / c_wr) held until c_ack. A forced one-cycle
// low gap separates consecutive cache requests.
//
// Ports:
//   c_clk, rst                     clock (rising edge), async active-high reset
//   addr, sys_wdata, sys_bval      request payload from the CPU
//   sys_rd, sys_wr                 request pulses (exactly one per request)
//   sys_rdata, sys_ack             read data and read-completion pulse
//   sys_wack                       write acknowledgment pulse
//   sys_busy, sys_err              queue full / dropped-request pulse
//   q_count                        number of occupied entries
//   c_addr, c_wdata, c_bval        head-entry payload to the cache
//   c_rd, c_wr                     cache request levels
//   c_rdata, c_ack                 cache read data and completion pulse
module cpu_req_queue #(
  parameter int ADDR_SIZE = 16,
  parameter int DATA_SIZE = 32,
  parameter int BVAL_SIZE = 4,
  parameter int DEPTH     = 4,
  parameter int POSTED_WR = 1
) (
  input  logic                         c_clk,
  input  logic                         rst,
  input  logic [ADDR_SIZE-1:0]         addr,
  input  logic [DATA_SIZE-1:0]         sys_wdata,
  input  logic [BVAL_SIZE-1:0]         sys_bval,
  input  logic                         sys_rd,
  input  logic                         sys_wr,
  output logic [DATA_SIZE-1:0]         sys_rdata,
  output logic                         sys_ack,
  output logic                         sys_wack,
  output logic                         sys_busy,
  output logic                         sys_err,
  output logic [$clog2(DEPTH+1)-1:0]   q_count,
  output logic [ADDR_SIZE-1:0]         c_addr,
  output logic [DATA_SIZE-1:0]         c_wdata,
  output logic [BVAL_SIZE-1:0]         c_bval,
  output logic                         c_rd,
  output logic                         c_wr,
  input  logic [DATA_SIZE-1:0]         c_rdata,
  input  logic                         c_ack
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = 1 + BVAL_SIZE + ADDR_SIZE + DATA_SIZE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Entry layout: {is_rd, bval, addr, wdata}
  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [ENT_W-1:0] head;
  state_t           state;
  state_t           state_nxt;
  logic             push;
  logic             pop;
  logic             load;
  logic             any_req;
  logic             bad_req;

  // Busy decodes only the registered count, so a pop in the same cycle
  // never opens a slot for a push while full.
  assign sys_busy = (q_count == CNT_W'(DEPTH));
  assign any_req  = sys_rd | sys_wr;
  assign bad_req  = sys_rd & sys_wr;
  assign push     = (sys_rd ^ sys_wr) & ~sys_busy;
  assign head     = mem[rd_ptr];

  // Request storage
  always_ff @(posedge c_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= {sys_rd, sys_bval, addr, sys_wdata};
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge c_clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + CNT_W'(1);
        2'b01:   q_count <= q_count - CNT_W'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge c_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state; load = present head to cache, pop = retire head
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (q_count != '0) begin
          state_nxt = REQ;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (c_ack) begin
          pop       = 1'b1;
          state_nxt = GAP;
        end else begin
          state_nxt = REQ;
        end
      end
      GAP: begin
        // Count here already reflects the pop taken on entry to GAP
        if (q_count != '0) begin
          state_nxt = REQ;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Cache-side request registers, held stable for the whole REQ state
  always_ff @(posedge c_clk or posedge rst) begin
    if (rst) begin
      c_addr  <= '0;
      c_wdata <= '0;
      c_bval  <= '0;
      c_rd    <= 1'b0;
      c_wr    <= 1'b0;
    end else if (load) begin
      c_wdata <= head[DATA_SIZE-1:0];
      c_addr  <= head[DATA_SIZE +: ADDR_SIZE];
      c_bval  <= head[DATA_SIZE+ADDR_SIZE +: BVAL_SIZE];
      c_rd    <= head[ENT_W-1];
      c_wr    <= ~head[ENT_W-1];
    end else if (pop) begin
      c_rd    <= 1'b0;
      c_wr    <= 1'b0;
    end else begin
      c_rd    <= c_rd;
      c_wr    <= c_wr;
    end
  end

  // CPU-side response pulses; c_rd/c_wr still identify the retiring entry
  always_ff @(posedge c_clk or posedge rst) begin
    if (rst) begin
      sys_rdata <= '0;
      sys_ack   <= 1'b0;
      sys_wack  <= 1'b0;
      sys_err   <= 1'b0;
    end else begin
      sys_ack <= pop & c_rd;
      sys_err <= bad_req | (any_req & sys_busy);
      if (pop && c_rd) sys_rdata <= c_rdata;
      else             sys_rdata <= sys_rdata;
      if (POSTED_WR != 0) sys_wack <= push & sys_wr;
      else                sys_wack <= pop & c_wr;
    end
  end

endmodule

// File: doc/cpu_req_queue.md
Name: cpu_req_queue

Overview:
- Single-clock CPU-to-cache request queue and the next generation of the CPU/cache interface.
- Accepts read and write pulses from the CPU, buffers up to DEPTH requests, and presents them to the cache one at a time with a level handshake.
- Returns read data, and write acknowledgments in posted or non-posted mode.
- Sits between the CPU model and the cache controller where both run on the cache clock.

Parameters:
ADDR_SIZE, 16, address width
DATA_SIZE, 32, data width
BVAL_SIZE, 4, byte-valid mask width
DEPTH, 4, queue entries; power of two, >=2
POSTED_WR, 1, 1 = ack writes on acceptance, 0 = ack writes on cache completion

Ports:
c_clk  in  1  clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-high
addr  in  ADDR_SIZE  request address
sys_wdata  in  DATA_SIZE  write data
sys_bval  in  BVAL_SIZE  byte-valid mask
sys_rd  in  1  read request pulse, one cycle per request
sys_wr  in  1  write request pulse, one cycle per request
sys_rdata  out  DATA_SIZE  read data, valid while sys_ack=1
sys_ack  out  1  read completion pulse
sys_wack  out  1  write acknowledgment pulse
sys_busy  out  1  queue full; requests in this cycle are dropped
sys_err  out  1  dropped-request pulse
q_count  out  $clog2(DEPTH+1)  occupied entries
c_addr  out  ADDR_SIZE  head-entry address to cache
c_wdata  out  DATA_SIZE  head-entry write data
c_bval  out  BVAL_SIZE  head-entry byte mask
c_rd  out  1  cache read request level
c_wr  out  1  cache write request level
c_rdata  in  DATA_SIZE  cache read data, valid with c_ack
c_ack  in  1  cache completion pulse

Behaviour:
- Reset (async, takes effect immediately):
  - q_count=0; read/write pointers=0; FSM=IDLE.
  - c_rd=c_wr=0; sys_ack=sys_wack=sys_err=0; sys_rdata=0.
  - c_addr/c_wdata/c_bval are don't-care but must not be X-propagating (register to 0).
- Reset mid-transaction abandons the in-flight cache request. A c_ack arriving after reset is ignored because the FSM is in IDLE.
- Entry format: {is_rd, bval, addr, wdata} = 1+BVAL_SIZE+ADDR_SIZE+DATA_SIZE bits.
- Accept:
  - Push at the edge where exactly one of sys_rd/sys_wr is 1 and sys_busy=0.
  - sys_busy = (q_count==DEPTH), decoded from registered count only.
  - A push in the same cycle as a pop while full is still rejected.
- Drop: sys_err=1 for one cycle after the edge if sys_rd&sys_wr=1, or if (sys_rd|sys_wr)=1 while sys_busy=1. The queue is unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally. q_count is +1 on push only, -1 on pop only, unchanged on push+pop.
- FSM states: IDLE, REQ, GAP.
  - IDLE: if q_count!=0, go to REQ and register the head entry onto c_addr/c_wdata/c_bval, setting c_rd=is_rd and c_wr=~is_rd.
  - REQ: hold c_* stable until c_ack=1 is sampled. On that edge: pop, c_rd=c_wr=0, go to GAP.
    - If the entry was a read: sys_rdata<=c_rdata, sys_ack=1 for one cycle.
    - If it was a write and POSTED_WR=0: sys_wack=1 for one cycle.
  - GAP: one cycle with c_rd=c_wr=0 (guaranteed low gap between requests). Next state is REQ with the new head if q_count!=0, else IDLE.
  - c_ack sampled in IDLE or GAP is ignored.
- Posted writes (POSTED_WR=1): sys_wack=1 for one cycle after the accepting edge; no wack on completion.
- sys_ack and sys_wack are independent outputs and may assert in the same cycle.
- Latency, empty queue, read accepted at edge N:
  - c_rd=1 after edge N+1.
  - c_ack at edge M gives sys_ack=1 during cycle after M.
  - Next request asserts after edge M+1.
- Ordering: strict FIFO; cache sees requests in acceptance order.

Test Plan:
- Read, empty queue: sys_rd at edge 1, addr=0x0010 -> c_rd=1 with c_addr=0x0010 after edge 2. c_ack with c_rdata=0xDEADBEEF -> sys_ack=1 and sys_rdata=0xDEADBEEF for one cycle; q_count back to 0.
- Posted vs non-posted write (run both modes), sys_wr addr=0x0020, wdata=0x12345678, bval=4'b0011:
  - POSTED_WR=1: sys_wack the cycle after accept.
  - POSTED_WR=0: sys_wack only after c_ack.
  - Both modes: c_wr=1 with the given data and mask.
- Full queue, DEPTH=4: 5 back-to-back reads with c_ack held 0 -> q_count=4, sys_busy=1, sys_err pulse on the 5th; after 4 c_acks, addresses are seen in order and the 5th is never issued.
- Back-to-back: 3 queued reads with c_ack returned immediately each time -> c_rd is low for exactly one cycle between requests and three sys_ack pulses occur in order.
- Illegal and stray inputs: sys_rd=sys_wr=1 -> sys_err pulse, q_count unchanged. c_ack in IDLE -> no sys_ack.
- Reset mid-operation: rst asserted while in REQ with 2 entries -> c_rd=0 immediately, q_count=0. A later c_ack is ignored and a new read then completes normally.
